// File: rtl/apb_bridge_nslave_if.sv
// Request/response port and APB bus bundles for the N-slave APB bridge.
// The request-side master is the interconnect; the APB-side master is the bridge.
interface apb_req_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_strb;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface apb_bus_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic [NUM_SLAVES-1:0]            PSEL;
  logic                             PENABLE;
  logic                             PWRITE;
  logic [ADDR_WIDTH-1:0]            PADDR;
  logic [DATA_WIDTH-1:0]            PWDATA;
  logic [DATA_WIDTH/8-1:0]          PSTRB;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]            PREADY;
  logic [NUM_SLAVES-1:0]            PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );
  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_bridge_nslave.sv
// Single-outstanding valid/ready to APB bridge with address-decoded slave select,
// decode-error response and wait-state timeout.
module apb_bridge_nslave #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic      PCLK,
  input  logic      PRESET,
  apb_req_if.slave  req,
  apb_bus_if.master apb
);
  localparam int SEL_BITS = $clog2(NUM_SLAVES);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic                  pwrite_q;
  logic [SEL_BITS-1:0]   idx_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [SEL_BITS-1:0]   req_idx;
  logic                  decode_ok;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] prdata_arr [NUM_SLAVES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_prdata
      assign prdata_arr[gi] = apb.PRDATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign req_idx     = req.req_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign decode_ok   = int'(req_idx) < NUM_SLAVES;
  assign sel_ready   = apb.PREADY[idx_q];
  assign sel_err     = apb.PSLVERR[idx_q];
  assign sel_rdata   = prdata_arr[idx_q];
  // Fires on the ACCESS cycle that would bring the wait count up to the limit.
  assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req.req_valid) state_d = decode_ok ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_d = RESP;
      RESP:    if (req.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req.req_ready = (state_q == IDLE);
    req.rsp_valid = (state_q == RESP);
    apb.PENABLE   = (state_q == ACCESS);
    apb.PSEL      = '0;
    if (state_q == SETUP || state_q == ACCESS) apb.PSEL = NUM_SLAVES'(1) << idx_q;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pwrite_q    <= 1'b0;
      idx_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (req.req_valid) begin
          paddr_q     <= req.req_addr;
          pwdata_q    <= req.req_wdata;
          pstrb_q     <= req.req_write ? req.req_strb : '0;
          pwrite_q    <= req.req_write;
          idx_q       <= req_idx;
          rsp_err_q   <= !decode_ok;
          rsp_rdata_q <= '0;
          cnt_q       <= '0;
        end
        ACCESS: begin
          if (sel_ready) begin
            rsp_err_q   <= sel_err;
            rsp_rdata_q <= (!pwrite_q && !sel_err) ? sel_rdata : '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign apb.PADDR     = paddr_q;
  assign apb.PWDATA    = pwdata_q;
  assign apb.PSTRB     = pstrb_q;
  assign apb.PWRITE    = pwrite_q;
  assign req.rsp_rdata = rsp_rdata_q;
  assign req.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_bridge_nslave.sv
// Directed plus randomized bench for apb_bridge_nslave: a 4-slave instance for the
// transfer/timeout/reset paths and a 3-slave instance for the decode-error path.
module tb_apb_bridge_nslave;
  localparam int TMO = 16;

  logic PCLK;
  logic PRESET;
  int   vectors;
  int   miscompares;

  apb_req_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32))                  rq  ();
  apb_bus_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_SLAVES(4))  ab  ();
  apb_req_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32))                  rq3 ();
  apb_bus_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_SLAVES(3))  ab3 ();

  apb_bridge_nslave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_SLAVES(4), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(rq.slave), .apb(ab.master)
  );
  apb_bridge_nslave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_SLAVES(3), .TIMEOUT(TMO)) dut3 (
    .PCLK(PCLK), .PRESET(PRESET), .req(rq3.slave), .apb(ab3.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // Reference: wt = number of low-PREADY ACCESS cycles before the slave answers.
  task automatic do_txn(input bit wr, input logic [9:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int wt, input bit serr,
                        input logic [31:0] rd, input int hold);
    int          idx;
    int          n_acc;
    bit          to;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_strb;
    logic [3:0]  onehot;
    idx      = int'(addr[9:8]);
    to       = (wt >= TMO);
    n_acc    = to ? TMO : wt + 1;
    exp_err  = to ? 1'b1 : serr;
    exp_rd   = (!wr && !exp_err) ? rd : 32'h0;
    exp_strb = wr ? strb : 4'h0;
    onehot   = 4'b0001 << idx;
    for (int s = 0; s < 4; s++) ab.PRDATA[s*32 +: 32] = (s == idx) ? rd : $urandom;
    ab.PSLVERR      = 4'($urandom);
    ab.PSLVERR[idx] = serr;
    ab.PREADY       = 4'($urandom);
    ab.PREADY[idx]  = 1'b0;
    check("idle_req_ready", 64'(rq.req_ready), 64'd1);
    rq.req_valid = 1'b1;
    rq.req_write = wr;
    rq.req_addr  = addr;
    rq.req_wdata = wdata;
    rq.req_strb  = strb;
    step();
    rq.req_valid = 1'b0;
    rq.req_write = 1'($urandom);
    rq.req_addr  = 10'($urandom);
    rq.req_wdata = $urandom;
    rq.req_strb  = 4'($urandom);
    check("setup_psel", 64'(ab.PSEL), 64'(onehot));
    check("setup_penable", 64'(ab.PENABLE), 64'd0);
    check("setup_paddr", 64'(ab.PADDR), 64'(addr));
    check("setup_pwrite", 64'(ab.PWRITE), 64'(wr));
    check("setup_pwdata", 64'(ab.PWDATA), 64'(wdata));
    check("setup_pstrb", 64'(ab.PSTRB), 64'(exp_strb));
    check("setup_req_ready", 64'(rq.req_ready), 64'd0);
    step();
    for (int k = 0; k < n_acc; k++) begin
      check("access_psel", 64'(ab.PSEL), 64'(onehot));
      check("access_penable", 64'(ab.PENABLE), 64'd1);
      check("access_paddr", 64'(ab.PADDR), 64'(addr));
      check("access_pwdata", 64'(ab.PWDATA), 64'(wdata));
      check("access_pstrb", 64'(ab.PSTRB), 64'(exp_strb));
      check("access_rsp_valid", 64'(rq.rsp_valid), 64'd0);
      if (k == wt) ab.PREADY[idx] = 1'b1;
      step();
      ab.PREADY[idx] = 1'b0;
    end
    check("resp_psel", 64'(ab.PSEL), 64'd0);
    check("resp_penable", 64'(ab.PENABLE), 64'd0);
    check("resp_valid", 64'(rq.rsp_valid), 64'd1);
    check("resp_err", 64'(rq.rsp_err), 64'(exp_err));
    check("resp_rdata", 64'(rq.rsp_rdata), 64'(exp_rd));
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", 64'(rq.rsp_valid), 64'd1);
      check("hold_err", 64'(rq.rsp_err), 64'(exp_err));
      check("hold_rdata", 64'(rq.rsp_rdata), 64'(exp_rd));
      check("hold_req_ready", 64'(rq.req_ready), 64'd0);
    end
    rq.rsp_ready = 1'b1;
    step();
    rq.rsp_ready = 1'b0;
    check("done_rsp_valid", 64'(rq.rsp_valid), 64'd0);
    check("done_req_ready", 64'(rq.req_ready), 64'd1);
    check("done_paddr_hold", 64'(ab.PADDR), 64'(addr));
    check("done_psel", 64'(ab.PSEL), 64'd0);
    $display("txn wr=%0d addr=%03h wait=%0d slverr=%0d err=%0d rdata=%08h", wr, addr, wt, serr,
             exp_err, exp_rd);
  endtask

  // 3-slave instance: every slave answers at once with rdata 0x11*(idx+1).
  task automatic txn3(input logic [9:0] addr);
    int         idx;
    logic [2:0] onehot;
    idx = int'(addr[9:8]);
    check("d3_req_ready", 64'(rq3.req_ready), 64'd1);
    rq3.req_valid = 1'b1;
    rq3.req_write = 1'b0;
    rq3.req_addr  = addr;
    step();
    rq3.req_valid = 1'b0;
    if (idx == 3) begin
      check("d3_dec_psel", 64'(ab3.PSEL), 64'd0);
      check("d3_dec_valid", 64'(rq3.rsp_valid), 64'd1);
      check("d3_dec_err", 64'(rq3.rsp_err), 64'd1);
      check("d3_dec_rdata", 64'(rq3.rsp_rdata), 64'd0);
    end else begin
      onehot = 3'b001 << idx;
      check("d3_setup_psel", 64'(ab3.PSEL), 64'(onehot));
      check("d3_setup_valid", 64'(rq3.rsp_valid), 64'd0);
      step();
      check("d3_access_penable", 64'(ab3.PENABLE), 64'd1);
      step();
      check("d3_resp_valid", 64'(rq3.rsp_valid), 64'd1);
      check("d3_resp_err", 64'(rq3.rsp_err), 64'd0);
      check("d3_resp_rdata", 64'(rq3.rsp_rdata), 64'(32'h11 * (idx + 1)));
    end
    rq3.rsp_ready = 1'b1;
    step();
    rq3.rsp_ready = 1'b0;
    check("d3_done_valid", 64'(rq3.rsp_valid), 64'd0);
    check("d3_done_ready", 64'(rq3.req_ready), 64'd1);
    $display("txn3 addr=%03h idx=%0d", addr, idx);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    PRESET       = 1'b1;
    rq.req_valid = 1'b0;  rq.req_write = 1'b0;  rq.req_addr = '0;
    rq.req_wdata = '0;    rq.req_strb  = '0;    rq.rsp_ready = 1'b0;
    ab.PRDATA    = '0;    ab.PREADY    = '0;    ab.PSLVERR   = '0;
    rq3.req_valid = 1'b0; rq3.req_write = 1'b0; rq3.req_addr = '0;
    rq3.req_wdata = '0;   rq3.req_strb  = '0;   rq3.rsp_ready = 1'b0;
    ab3.PRDATA   = {32'h33, 32'h22, 32'h11};
    ab3.PREADY   = 3'b111;
    ab3.PSLVERR  = 3'b000;
    step();
    step();
    PRESET = 1'b0;
    check("rst_req_ready", 64'(rq.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rq.rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rq.rsp_err), 64'd0);
    check("rst_rsp_rdata", 64'(rq.rsp_rdata), 64'd0);
    check("rst_psel", 64'(ab.PSEL), 64'd0);
    check("rst_penable", 64'(ab.PENABLE), 64'd0);
    check("rst_pwrite", 64'(ab.PWRITE), 64'd0);
    check("rst_paddr", 64'(ab.PADDR), 64'd0);
    check("rst_pwdata", 64'(ab.PWDATA), 64'd0);
    check("rst_pstrb", 64'(ab.PSTRB), 64'd0);
    $display("reset state checked");

    do_txn(1'b1, 10'h104, 32'h0A5A5A5A, 4'hF, 0, 1'b0, 32'h0, 0);
    ab.PRDATA[31:0] = 32'h1;
    do_txn(1'b0, 10'h3F0, 32'h12345678, 4'h5, 3, 1'b0, 32'hDEADBEEF, 0);
    do_txn(1'b0, 10'h2A0, 32'h0, 4'h0, 0, 1'b1, 32'hCAFEF00D, 5);
    do_txn(1'b0, 10'h010, 32'h0, 4'h0, 100, 1'b0, 32'h55AA55AA, 1);
    do_txn(1'b0, 10'h020, 32'h0, 4'h0, TMO - 1, 1'b0, 32'h13572468, 0);
    do_txn(1'b1, 10'h330, 32'hFFFF0000, 4'h3, TMO, 1'b0, 32'h0, 0);

    txn3(10'h3F0);
    txn3(10'h304);
    txn3(10'h0F0);
    txn3(10'h200);

    // Reset during ACCESS aborts the transfer without a response.
    ab.PREADY    = 4'h0;
    rq.req_valid = 1'b1;
    rq.req_write = 1'b1;
    rq.req_addr  = 10'h208;
    rq.req_wdata = 32'hA1B2C3D4;
    rq.req_strb  = 4'h9;
    step();
    rq.req_valid = 1'b0;
    step();
    check("rstx_access_penable", 64'(ab.PENABLE), 64'd1);
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    check("rstx_psel", 64'(ab.PSEL), 64'd0);
    check("rstx_penable", 64'(ab.PENABLE), 64'd0);
    check("rstx_req_ready", 64'(rq.req_ready), 64'd1);
    check("rstx_rsp_valid", 64'(rq.rsp_valid), 64'd0);
    check("rstx_paddr", 64'(ab.PADDR), 64'd0);
    $display("reset during ACCESS checked");
    do_txn(1'b0, 10'h1C4, 32'h0, 4'h0, 1, 1'b0, 32'h600DCAFE, 0);

    for (int t = 0; t < 40; t++) begin
      int r;
      int wt;
      r  = int'($urandom_range(0, 9));
      wt = (r < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(TMO - 2, TMO + 2));
      do_txn(1'($urandom), 10'($urandom), $urandom, 4'($urandom), wt,
             ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 2)));
    end
    for (int t = 0; t < 8; t++) txn3(10'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
